dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester controller in front of the single-port, word-addressed data memory: port 0 is the CPU load/store stage, port 1 is the debug/DMA loader.
- Serialises accesses and arbitrates round-robin between the ports.
- Implements byte-enable writes by sequencing read-modify-write on the word-only memory.
- Screens out-of-range addresses before they reach the memory.

Parameters:
- ADDR_W, 12, word-address width.
- DEPTH, 3072, number of implemented words; addresses >= DEPTH are errors.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority to port 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- p0_valid, p1_valid  in  1 each  request valid
- p0_ready, p1_ready  out  1 each  request accepted this cycle
- p0_we, p1_we  in  1 each  1 = write, 0 = read
- p0_addr, p1_addr  in  ADDR_W each  word address
- p0_wdata, p1_wdata  in  32 each  write data
- p0_be, p1_be  in  4 each  byte enables; bit i covers bits [8i+7:8i]
- p0_pc  in  32  PC of the CPU access, forwarded for the memory's write log
- p0_resp_valid, p1_resp_valid  out  1 each  single-cycle completion pulse
- p0_resp_rdata, p1_resp_rdata  out  32 each  read data
- p0_resp_err, p1_resp_err  out  1 each  address out of range
- dm_we  out  1  memory write enable
- dm_addr  out  ADDR_W  memory word address
- dm_wdata  out  32  memory write data
- dm_pc  out  32  PC forwarded to the memory (always 0 for port 1)
- dm_rdata  in  32  combinational memory read data

Behaviour:
- Reset:
  - State returns to IDLE; the round-robin pointer favours port 0.
  - All outputs are 0 and all latched request registers clear.
  - dm_we is gated by !reset, so no write is issued in the reset cycle even mid-operation.
  - An aborted transaction produces no response.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - Winner selection: if exactly one port is valid, it wins. If both are valid, the pointer's port wins (RR_EN=1), otherwise port 0.
  - The winner's ready is asserted combinationally in the same cycle; the loser's ready stays 0.
  - On acceptance, latch owner, we, addr, wdata, be and pc (pc = 0 for port 1).
  - Next state:
    - addr >= DEPTH -> RESP with err = 1.
    - we = 1 and be = 0 -> RESP (no memory access).
    - we = 0 -> RD.
    - we = 1 and be = 4'b1111 -> WR.
    - we = 1 with a partial be -> RD.
  - Reads ignore be; full words are always returned.
- RD: drive dm_addr = latched addr with dm_we = 0 and capture dm_rdata into rdata_q. Go to WR if latched we = 1, else RESP.
- WR:
  - Drive dm_we = 1, dm_addr, and dm_pc = latched pc.
  - dm_wdata byte i = be[i] ? wdata byte i : rdata_q byte i. For a full write rdata_q is unused.
  - Go to RESP.
- RESP:
  - Owner's resp_valid = 1 for exactly one cycle.
  - resp_rdata = rdata_q for reads, 0 for writes; resp_err as latched.
  - Non-owner response outputs are 0.
  - Pointer moves to the other port (RR_EN=1). Go to IDLE.
- Outside WR, dm_we = 0. dm_addr and dm_pc are 0 in IDLE and RESP.
- Latency from the accept cycle (cycle 0):
  - Read: RD at 1, resp at 2.
  - Full write: memory write at 1, resp at 2.
  - Partial write: RD at 1, WR at 2, resp at 3.
  - Error / no-op: resp at 1.
- Throughput: no acceptance outside IDLE; ready is 0 in RD, WR and RESP. Requesters must hold valid and payload stable until ready.
- Simultaneous events: both ports are served alternately under continuous contention (RR_EN=1). A requester that deasserts valid before ready is simply not served.
- Address DEPTH-1 (3071) is valid; 3072 and 4095 are errors and never reach the memory.

Test Plan:
- Reset, then p0 read addr 5 (memory preset 0xDEADBEEF) -> p0_ready at cycle 0, p0_resp_valid at cycle 2 with rdata 0xDEADBEEF, err 0; dm_we stays 0 throughout.
- p0 write addr 7, wdata 0x12345678, be 1111, pc 0x3000 -> dm_we = 1 only at cycle 1 with dm_addr 7, dm_wdata 0x12345678, dm_pc 0x3000; resp at cycle 2.
- Word 9 holds 0xAABBCCDD; p1 write wdata 0x11223344, be 0101 -> RD at 1, WR at 2 with dm_wdata 0xAA22CC44 and dm_pc 0; resp at 3.
- Both ports valid continuously with 4 reads each -> grant order p0, p1, p0, p1, …; each transaction takes 3 cycles. With RR_EN=0 all p0 requests complete first.
- p0 read addr 3072 and then addr 3071 -> first: resp at cycle 1, err 1, rdata 0, no memory access; second: normal read.
- reset asserted during WR of a partial write -> no dm_we in the reset cycle, no resp_valid; state is IDLE and outputs are 0 the next cycle.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the word-only data memory: serialises CPU and
// debug/DMA accesses, screens out-of-range addresses, and splits partial writes into read-modify-write.
module dm_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 3072,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_be,
    input  logic [31:0]       p0_pc,
    output logic              p0_resp_valid,
    output logic [31:0]       p0_resp_rdata,
    output logic              p0_resp_err,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_be,
    output logic              p1_resp_valid,
    output logic [31:0]       p1_resp_rdata,
    output logic              p1_resp_err,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [31:0]       dm_pc,
    input  logic [31:0]       dm_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              gnt0, gnt1;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic [31:0]       req_pc;
    logic              req_oor;
    logic [31:0]       merged;

    // Grant only from IDLE; ready is suppressed while reset is held
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_IDLE && !reset) begin
            if (p0_valid && p1_valid) begin
                if (RR_EN && ptr_q) gnt1 = 1'b1;
                else                gnt0 = 1'b1;
            end else if (p0_valid) begin
                gnt0 = 1'b1;
            end else if (p1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign p0_ready  = gnt0;
    assign p1_ready  = gnt1;
    assign req_we    = gnt1 ? p1_we    : p0_we;
    assign req_addr  = gnt1 ? p1_addr  : p0_addr;
    assign req_wdata = gnt1 ? p1_wdata : p0_wdata;
    assign req_be    = gnt1 ? p1_be    : p0_be;
    assign req_pc    = gnt1 ? 32'h0    : p0_pc;
    assign req_oor   = ({1'b0, req_addr} >= DEPTH_EXT);

    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : rdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    pc_d    = req_pc;
                    rdata_d = '0;
                    err_d   = req_oor;
                    if (req_oor)                     state_d = S_RESP;
                    else if (req_we && req_be == '0) state_d = S_RESP;
                    else if (!req_we)                state_d = S_RD;
                    else if (req_be == '1)           state_d = S_WR;
                    else                             state_d = S_RD;
                end
            end
            S_RD: begin
                rdata_d = dm_rdata;
                state_d = we_q ? S_WR : S_RESP;
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (RR_EN) ptr_d = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is forced low during reset, including a write in flight
    always_comb begin
        dm_we         = 1'b0;
        dm_addr       = '0;
        dm_wdata      = '0;
        dm_pc         = '0;
        p0_resp_valid = 1'b0;
        p0_resp_rdata = '0;
        p0_resp_err   = 1'b0;
        p1_resp_valid = 1'b0;
        p1_resp_rdata = '0;
        p1_resp_err   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_RD: begin
                    dm_addr = addr_q;
                end
                S_WR: begin
                    dm_we    = 1'b1;
                    dm_addr  = addr_q;
                    dm_wdata = merged;
                    dm_pc    = pc_q;
                end
                S_RESP: begin
                    if (owner_q) begin
                        p1_resp_valid = 1'b1;
                        p1_resp_rdata = we_q ? 32'h0 : rdata_q;
                        p1_resp_err   = err_q;
                    end else begin
                        p0_resp_valid = 1'b1;
                        p0_resp_rdata = we_q ? 32'h0 : rdata_q;
                        p0_resp_err   = err_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized single transactions
// checked against a word-array memory model with byte-merge arithmetic.
module tb_dm_arbiter;

    localparam int DEPTH = 3072;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        p0_valid, p0_ready, p0_we, p0_resp_valid, p0_resp_err;
    logic [11:0] p0_addr;
    logic [31:0] p0_wdata, p0_pc, p0_resp_rdata;
    logic [3:0]  p0_be;
    logic        p1_valid, p1_ready, p1_we, p1_resp_valid, p1_resp_err;
    logic [11:0] p1_addr;
    logic [31:0] p1_wdata, p1_resp_rdata;
    logic [3:0]  p1_be;
    logic        dm_we;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata, dm_pc, dm_rdata;

    logic        f0_valid, f1_valid;
    logic [11:0] f0_addr, f1_addr;
    logic        fp_p0_ready, fp_p1_ready, fp_p0_rv, fp_p1_rv, fp_p0_err, fp_p1_err, fp_dm_we;
    logic [31:0] fp_p0_rd, fp_p1_rd, fp_dm_wdata, fp_dm_pc, fp_dm_rdata;
    logic [11:0] fp_dm_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];

    int          o_acc, o_lat, o_nresp, o_nwr, o_wrcyc;
    logic [31:0] o_rdata, o_wdata, o_pc;
    logic [11:0] o_waddr;
    logic        o_err, o_other, o_touch;

    dm_arbiter #(.ADDR_W(12), .DEPTH(DEPTH), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_pc(p0_pc),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc), .dm_rdata(dm_rdata)
    );

    dm_arbiter #(.ADDR_W(12), .DEPTH(DEPTH), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_valid(f0_valid), .p0_ready(fp_p0_ready), .p0_we(1'b0), .p0_addr(f0_addr),
        .p0_wdata(32'h0), .p0_be(4'h0), .p0_pc(32'h0),
        .p0_resp_valid(fp_p0_rv), .p0_resp_rdata(fp_p0_rd), .p0_resp_err(fp_p0_err),
        .p1_valid(f1_valid), .p1_ready(fp_p1_ready), .p1_we(1'b0), .p1_addr(f1_addr),
        .p1_wdata(32'h0), .p1_be(4'h0),
        .p1_resp_valid(fp_p1_rv), .p1_resp_rdata(fp_p1_rd), .p1_resp_err(fp_p1_err),
        .dm_we(fp_dm_we), .dm_addr(fp_dm_addr), .dm_wdata(fp_dm_wdata), .dm_pc(fp_dm_pc),
        .dm_rdata(fp_dm_rdata)
    );

    assign dm_rdata    = mem[dm_addr];
    assign fp_dm_rdata = {20'h0, fp_dm_addr};

    always @(posedge clk) begin
        if (dm_we) begin
            if (dm_addr >= 12'd3072) begin
                errors++;
                $display("FAIL dm_we_range addr=%0d required <%0d", dm_addr, DEPTH);
            end
            mem[dm_addr] <= dm_wdata;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        p0_valid = 1'b0; p1_valid = 1'b0; f0_valid = 1'b0; f1_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one request on one port and records what the DUT does around it
    task automatic run_txn(input bit port, input bit we, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] pc);
        logic rdy, rv, orv;
        o_acc = -1; o_lat = -1; o_nresp = 0; o_nwr = 0; o_wrcyc = -1;
        o_rdata = '0; o_wdata = '0; o_pc = '0; o_waddr = '0;
        o_err = 1'b0; o_other = 1'b0; o_touch = 1'b0;
        @(negedge clk);
        if (port) begin
            p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be;
        end else begin
            p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be; p0_pc = pc;
        end
        for (int c = 0; c < 20; c++) begin
            #1;
            rdy = port ? p1_ready : p0_ready;
            if (rdy) begin
                o_acc = c;
                break;
            end
            @(negedge clk);
        end
        if (dm_we) begin
            o_nwr++; o_wrcyc = 0;
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            p0_valid = 1'b0; p1_valid = 1'b0;
            #1;
            if (dm_we) begin
                o_nwr++; o_wrcyc = c; o_waddr = dm_addr; o_wdata = dm_wdata; o_pc = dm_pc;
            end
            if (dm_addr != 12'd0 || dm_we) o_touch = 1'b1;
            rv  = port ? p1_resp_valid : p0_resp_valid;
            orv = port ? p0_resp_valid : p1_resp_valid;
            if (orv) o_other = 1'b1;
            if (rv) begin
                o_nresp++;
                if (o_lat < 0) begin
                    o_lat = c;
                    o_rdata = port ? p1_resp_rdata : p0_resp_rdata;
                    o_err = port ? p1_resp_err : p0_resp_err;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 12'd1;
        #1;
        checks++;
        if ({p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, dm_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=00000",
                     {p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, dm_we});
        end
        do_reset();
        #1;
        checks++;
        if ({p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err, dm_we} !== 7'b0) begin
            errors++;
            $display("FAIL idle_ctrl got=%b required=0",
                     {p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err, dm_we});
        end
        checks++;
        if ({dm_addr, dm_wdata, dm_pc, p0_resp_rdata, p1_resp_rdata} !== '0) begin
            errors++;
            $display("FAIL idle_data got addr=%h wdata=%h pc=%h required all 0", dm_addr, dm_wdata, dm_pc);
        end
    endtask

    task automatic test_read();
        mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        run_txn(1'b0, 1'b0, 12'd5, 32'h0, 4'h0, 32'h0);
        checks++;
        if (o_acc !== 0) begin errors++; $display("FAIL read_ready got=%0d required=0", o_acc); end
        checks++;
        if (o_lat !== 2) begin errors++; $display("FAIL read_lat got=%0d required=2", o_lat); end
        checks++;
        if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin
            errors++; $display("FAIL read_data got=%h err=%b required=deadbeef err=0", o_rdata, o_err);
        end
        checks++;
        if (o_nwr !== 0 || o_nresp !== 1) begin
            errors++; $display("FAIL read_side got nwr=%0d nresp=%0d required 0/1", o_nwr, o_nresp);
        end
    endtask

    task automatic test_full_write();
        run_txn(1'b0, 1'b1, 12'd7, 32'h12345678, 4'hF, 32'h3000);
        ref_mem[7] = 32'h12345678;
        checks++;
        if (o_nwr !== 1 || o_wrcyc !== 1) begin
            errors++; $display("FAIL fwr_cycle got nwr=%0d cyc=%0d required 1/1", o_nwr, o_wrcyc);
        end
        checks++;
        if (o_waddr !== 12'd7 || o_wdata !== 32'h12345678 || o_pc !== 32'h3000) begin
            errors++; $display("FAIL fwr_bus got a=%0d d=%h pc=%h required 7/12345678/3000", o_waddr, o_wdata, o_pc);
        end
        checks++;
        if (o_lat !== 2 || o_rdata !== 32'h0) begin
            errors++; $display("FAIL fwr_resp got lat=%0d rdata=%h required 2/0", o_lat, o_rdata);
        end
    endtask

    task automatic test_partial_write();
        mem[9] = 32'hAABBCCDD; ref_mem[9] = 32'hAABBCCDD;
        run_txn(1'b1, 1'b1, 12'd9, 32'h11223344, 4'b0101, 32'h0);
        ref_mem[9] = 32'hAA22CC44;
        checks++;
        if (o_nwr !== 1 || o_wrcyc !== 2) begin
            errors++; $display("FAIL pwr_cycle got nwr=%0d cyc=%0d required 1/2", o_nwr, o_wrcyc);
        end
        checks++;
        if (o_wdata !== 32'hAA22CC44 || o_pc !== 32'h0) begin
            errors++; $display("FAIL pwr_merge got d=%h pc=%h required aa22cc44/0", o_wdata, o_pc);
        end
        checks++;
        if (o_lat !== 3 || o_other !== 1'b0) begin
            errors++; $display("FAIL pwr_resp got lat=%0d other=%b required 3/0", o_lat, o_other);
        end
    endtask

    task automatic test_errors();
        run_txn(1'b0, 1'b0, 12'd3072, 32'h0, 4'h0, 32'h0);
        checks++;
        if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_touch !== 1'b0) begin
            errors++;
            $display("FAIL err_3072 got lat=%0d err=%b rdata=%h touch=%b required 1/1/0/0", o_lat, o_err, o_rdata, o_touch);
        end
        mem[3071] = 32'h5A5A0FF0; ref_mem[3071] = 32'h5A5A0FF0;
        run_txn(1'b0, 1'b0, 12'd3071, 32'h0, 4'h0, 32'h0);
        checks++;
        if (o_lat !== 2 || o_err !== 1'b0 || o_rdata !== 32'h5A5A0FF0) begin
            errors++; $display("FAIL edge_3071 got lat=%0d err=%b rdata=%h required 2/0/5a5a0ff0", o_lat, o_err, o_rdata);
        end
        run_txn(1'b1, 1'b1, 12'd4095, 32'hFFFFFFFF, 4'hF, 32'h0);
        checks++;
        if (o_lat !== 1 || o_err !== 1'b1 || o_nwr !== 0) begin
            errors++; $display("FAIL err_4095 got lat=%0d err=%b nwr=%0d required 1/1/0", o_lat, o_err, o_nwr);
        end
        run_txn(1'b0, 1'b1, 12'd11, 32'hFFFFFFFF, 4'h0, 32'h0);
        checks++;
        if (o_lat !== 1 || o_err !== 1'b0 || o_nwr !== 0) begin
            errors++; $display("FAIL noop_be0 got lat=%0d err=%b nwr=%0d required 1/0/0", o_lat, o_err, o_nwr);
        end
    endtask

    // Both ports saturated with reads; rr selects which instance is exercised
    task automatic test_back_to_back(input bit rr);
        int n0, n1, nresp, both;
        int order[$];
        int gcyc[$];
        logic [11:0] q0[$];
        logic [11:0] q1[$];
        logic [11:0] a;
        logic r0, r1, v0, v1, side;
        logic [31:0] d0, d1, exp_d;
        do_reset();
        n0 = 0; n1 = 0; nresp = 0; both = 0; side = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rr) begin
                p0_valid = (n0 < 4); p0_we = 1'b0; p0_addr = 12'(100 + n0);
                p1_valid = (n1 < 4); p1_we = 1'b0; p1_addr = 12'(200 + n1);
            end else begin
                f0_valid = (n0 < 4); f0_addr = 12'(300 + n0);
                f1_valid = (n1 < 4); f1_addr = 12'(400 + n1);
            end
            #1;
            r0 = rr ? p0_ready : fp_p0_ready;
            r1 = rr ? p1_ready : fp_p1_ready;
            v0 = rr ? p0_resp_valid : fp_p0_rv;
            v1 = rr ? p1_resp_valid : fp_p1_rv;
            d0 = rr ? p0_resp_rdata : fp_p0_rd;
            d1 = rr ? p1_resp_rdata : fp_p1_rd;
            if (!rr && (fp_dm_we || fp_p0_err || fp_p1_err || fp_dm_wdata != 32'h0 || fp_dm_pc != 32'h0)) side = 1'b1;
            if (r0 && r1) both++;
            if (r0) begin order.push_back(0); gcyc.push_back(c); q0.push_back(rr ? p0_addr : f0_addr); n0++; end
            if (r1) begin order.push_back(1); gcyc.push_back(c); q1.push_back(rr ? p1_addr : f1_addr); n1++; end
            if (v0 && q0.size() > 0) begin
                a = q0.pop_front();
                exp_d = rr ? ref_mem[a] : {20'h0, a};
                nresp++;
                checks++;
                if (d0 !== exp_d) begin errors++; $display("FAIL b2b_p0_rdata rr=%0d got=%h required=%h", rr, d0, exp_d); end
            end
            if (v1 && q1.size() > 0) begin
                a = q1.pop_front();
                exp_d = rr ? ref_mem[a] : {20'h0, a};
                nresp++;
                checks++;
                if (d1 !== exp_d) begin errors++; $display("FAIL b2b_p1_rdata rr=%0d got=%h required=%h", rr, d1, exp_d); end
            end
        end
        p0_valid = 1'b0; p1_valid = 1'b0; f0_valid = 1'b0; f1_valid = 1'b0;
        checks++;
        if (order.size() !== 8 || nresp !== 8 || both !== 0) begin
            errors++; $display("FAIL b2b_counts rr=%0d got grants=%0d resps=%0d both=%0d required 8/8/0", rr, order.size(), nresp, both);
        end
        for (int i = 0; i < order.size() && i < 8; i++) begin
            checks++;
            if (order[i] !== (rr ? (i % 2) : (i / 4))) begin
                errors++; $display("FAIL b2b_order rr=%0d idx=%0d got=p%0d required=p%0d", rr, i, order[i], rr ? (i % 2) : (i / 4));
            end
            checks++;
            if (gcyc[i] - gcyc[0] !== 3 * i) begin
                errors++; $display("FAIL b2b_spacing rr=%0d idx=%0d got=%0d required=%0d", rr, i, gcyc[i] - gcyc[0], 3 * i);
            end
        end
        if (!rr) begin
            checks++;
            if (side !== 1'b0) begin errors++; $display("FAIL fp_side got=1 required=0"); end
        end
    endtask

    task automatic test_reset_mid_write();
        mem[20] = 32'h01020304; ref_mem[20] = 32'h01020304;
        @(negedge clk);
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 12'd20; p0_wdata = 32'hFFFFFFFF; p0_be = 4'b0011; p0_pc = 32'h44;
        #1;
        checks++;
        if (p0_ready !== 1'b1) begin errors++; $display("FAIL rst_accept got=%b required=1", p0_ready); end
        @(negedge clk);
        p0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (dm_we !== 1'b0 || p0_resp_valid !== 1'b0 || p1_resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_wr_gate got we=%b rv=%b%b required 0/00", dm_we, p0_resp_valid, p1_resp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({p0_ready, p1_ready, p0_resp_valid, p1_resp_valid, dm_we, dm_addr, dm_wdata, dm_pc} !== '0) begin
            errors++; $display("FAIL rst_after got we=%b addr=%0d rv=%b required all 0", dm_we, dm_addr, p0_resp_valid);
        end
        checks++;
        if (mem[20] !== 32'h01020304) begin errors++; $display("FAIL rst_mem got=%h required=01020304", mem[20]); end
        run_txn(1'b0, 1'b0, 12'd20, 32'h0, 4'h0, 32'h0);
        checks++;
        if (o_acc !== 0 || o_lat !== 2 || o_rdata !== 32'h01020304) begin
            errors++; $display("FAIL rst_resume got acc=%0d lat=%0d rdata=%h required 0/2/01020304", o_acc, o_lat, o_rdata);
        end
    endtask

    task automatic test_random();
        bit          port, we, oor;
        logic [11:0] addr;
        logic [31:0] wdata, pc, exp_w, exp_r, cur;
        logic [3:0]  be;
        int          exp_lat, exp_nwr, bad;
        for (int t = 0; t < 80; t++) begin
            port  = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 7) == 0) ? 12'(3072 + $urandom_range(0, 1023)) : 12'($urandom_range(0, 3071));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            pc    = $urandom;
            oor   = (addr >= 12'd3072);
            exp_lat = (oor || (we && be == 4'h0)) ? 1 : (we && be != 4'hF) ? 3 : 2;
            exp_nwr = (!oor && we && be != 4'h0) ? 1 : 0;
            exp_r   = (!oor && !we) ? ref_mem[addr] : 32'h0;
            cur     = ref_mem[addr];
            exp_w   = cur;
            for (int b = 0; b < 4; b++) if (be[b]) exp_w[8*b +: 8] = wdata[8*b +: 8];
            run_txn(port, we, addr, wdata, be, pc);
            if (exp_nwr == 1) ref_mem[addr] = exp_w;
            checks++;
            if (o_acc !== 0 || o_lat !== exp_lat || o_nresp !== 1 || o_other !== 1'b0) begin
                errors++; $display("FAIL rnd_timing t=%0d got acc=%0d lat=%0d nresp=%0d other=%b required 0/%0d/1/0",
                                   t, o_acc, o_lat, o_nresp, o_other, exp_lat);
            end
            checks++;
            if (o_rdata !== exp_r || o_err !== oor) begin
                errors++; $display("FAIL rnd_resp t=%0d got rdata=%h err=%b required %h/%b", t, o_rdata, o_err, exp_r, oor);
            end
            checks++;
            if (o_nwr !== exp_nwr) begin
                errors++; $display("FAIL rnd_nwr t=%0d got=%0d required=%0d", t, o_nwr, exp_nwr);
            end else if (exp_nwr == 1) begin
                checks++;
                if (o_waddr !== addr || o_wdata !== exp_w || o_wrcyc !== exp_lat - 1 || o_pc !== (port ? 32'h0 : pc)) begin
                    errors++; $display("FAIL rnd_write t=%0d got a=%0d d=%h cyc=%0d pc=%h required %0d/%h/%0d/%h",
                                       t, o_waddr, o_wdata, o_wrcyc, o_pc, addr, exp_w, exp_lat - 1, port ? 32'h0 : pc);
                end
            end
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rnd_mem_image got=%0d differing words required=0", bad); end
    endtask

    initial begin
        reset = 1'b1;
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_be = '0; p0_pc = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
        f0_valid = 1'b0; f1_valid = 1'b0; f0_addr = '0; f1_addr = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_read();
        test_full_write();
        test_partial_write();
        test_errors();
        test_back_to_back(1'b1);
        test_back_to_back(1'b0);
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
